// File: rtl/pinmux_cfg_pkg.sv
// Shared types and constants for the DP0 pinmux configuration sequencer.
package pinmux_cfg_pkg;

  localparam int DP0_NUM_PADS  = 32;
  localparam int DP0_SEL_WIDTH = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GATE    = 3'd1,
    ST_APPLY   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_RELEASE = 3'd4
  } cfg_state_e;

  // LSB position of a pad's slice within the packed muxsel bus.
  function automatic int sel_lsb(input int pad, input int sel_w);
    return pad * sel_w;
  endfunction

endpackage

// File: rtl/pinmux_cfg_settle_timer.sv
// Loadable down-counter; o_expired marks the last cycle of a LOAD_VAL-cycle window.
module pinmux_cfg_settle_timer
  import pinmux_cfg_pkg::*;
#(
  parameter int LOAD_VAL = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expired
);

  localparam int CNT_W = $clog2(LOAD_VAL + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(LOAD_VAL);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pinmux_cfg_sequencer.sv
// Serialises pad reconfiguration requests into gate/apply/settle/release sequences.
// Optional pad locking is compiled in with `define PINMUX_CFG_LOCK_EN.
module pinmux_cfg_sequencer
  import pinmux_cfg_pkg::*;
#(
  parameter int NUM_PADS      = DP0_NUM_PADS,
  parameter int SEL_WIDTH     = DP0_SEL_WIDTH,
  parameter int IDX_WIDTH     = 5,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [IDX_WIDTH-1:0]          req_pad_idx,
  input  logic [SEL_WIDTH-1:0]          req_muxsel,
  input  logic                          req_dir,
  output logic [NUM_PADS*SEL_WIDTH-1:0] pinmux_muxsel_out_mscbus,
  output logic [NUM_PADS-1:0]           dir_out_mscbus,
  output logic [NUM_PADS-1:0]           pad_oe_gate,
  output logic                          busy,
  output logic                          done_pulse,
  output logic                          err_pulse
`ifdef PINMUX_CFG_LOCK_EN
  ,
  input  logic                          lock_req,
  output logic [NUM_PADS-1:0]           pad_locked
`endif
);

  localparam int BUS_W = NUM_PADS * SEL_WIDTH;

  cfg_state_e           r_state;
  logic [BUS_W-1:0]     r_muxsel;
  logic [NUM_PADS-1:0]  r_dir;
  logic [NUM_PADS-1:0]  r_gate;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [SEL_WIDTH-1:0] r_sel;
  logic                 r_new_dir;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_idx_ok;
  logic                 w_locked_hit;
  logic                 w_reject;
  logic                 w_same;
  logic                 w_timer_load;
  logic                 w_expired;
  logic [NUM_PADS-1:0]  w_req_onehot;
  logic [NUM_PADS-1:0]  w_cur_onehot;
  logic [SEL_WIDTH-1:0] w_cur_sel;
  logic                 w_cur_dir;
  logic [BUS_W-1:0]     w_sel_mask;
  logic [BUS_W-1:0]     w_sel_new;

  assign w_accept     = req_valid & (r_state == ST_IDLE);
  assign w_idx_ok     = int'(req_pad_idx) < NUM_PADS;
  assign w_req_onehot = NUM_PADS'(1) << req_pad_idx;
  assign w_cur_sel    = SEL_WIDTH'(r_muxsel >> sel_lsb(int'(req_pad_idx), SEL_WIDTH));
  assign w_cur_dir    = |(r_dir & w_req_onehot);
  assign w_same       = (w_cur_sel == req_muxsel) && (w_cur_dir == req_dir);
  assign w_reject     = ~w_idx_ok | w_locked_hit;

  // Timer reloads on the way into GATE and on the way out of APPLY into SETTLE.
  assign w_timer_load = (w_accept & ~w_reject & ~w_same) | (r_state == ST_APPLY);

  assign w_cur_onehot = NUM_PADS'(1) << r_idx;
  assign w_sel_mask   = BUS_W'({SEL_WIDTH{1'b1}}) << sel_lsb(int'(r_idx), SEL_WIDTH);
  assign w_sel_new    = BUS_W'(r_sel) << sel_lsb(int'(r_idx), SEL_WIDTH);

  pinmux_cfg_settle_timer #(
    .LOAD_VAL (SETTLE_CYCLES)
  ) u_settle_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_timer_load),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_muxsel  <= '0;
      r_dir     <= '0;
      r_gate    <= '0;
      r_idx     <= '0;
      r_sel     <= '0;
      r_new_dir <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept & w_reject;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_reject) begin
            r_idx     <= req_pad_idx;
            r_sel     <= req_muxsel;
            r_new_dir <= req_dir;
            if (w_same) begin
              r_state <= ST_RELEASE;
            end else begin
              r_state <= ST_GATE;
              r_gate  <= w_req_onehot;
            end
          end
        end
        ST_GATE: begin
          if (w_expired) r_state <= ST_APPLY;
        end
        ST_APPLY: begin
          r_muxsel <= (r_muxsel & ~w_sel_mask) | w_sel_new;
          r_dir    <= r_new_dir ? (r_dir | w_cur_onehot) : (r_dir & ~w_cur_onehot);
          r_state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_expired) r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          r_gate  <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PINMUX_CFG_LOCK_EN
  logic [NUM_PADS-1:0] r_locked;

  // Lock snapshots every pad currently configured as output; bits stay set until reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_locked <= '0;
    end else if (lock_req && (r_state == ST_IDLE)) begin
      r_locked <= r_locked | r_dir;
    end
  end

  assign w_locked_hit = |(r_locked & w_req_onehot);
  assign pad_locked   = r_locked;
`else
  assign w_locked_hit = 1'b0;
`endif

  assign req_ready                = (r_state == ST_IDLE);
  assign busy                     = (r_state != ST_IDLE);
  assign done_pulse               = (r_state == ST_RELEASE);
  assign err_pulse                = r_err;
  assign pinmux_muxsel_out_mscbus = r_muxsel;
  assign dir_out_mscbus           = r_dir;
  assign pad_oe_gate              = r_gate;

endmodule
